pic_ack_sequencer: RTL and testbench

//  Clocked interrupt-acknowledge sequencer and scheduler for the 8-input PIC. Latches

---
 rtl/pic_ack_sequencer.sv | 172 +++++++++++++++++
 tb/tb_pic_ack_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pic_ack_sequencer.sv
// -----------------------------------------------------------------------------
// pic_ack_sequencer
//   Interrupt-acknowledge sequencer and scheduler for an 8-input PIC.
//   - Latches synchronised rising edges of ir_in into IRR and applies IMR.
//   - Picks the fixed-priority winner (IR0 highest) and compares it against
//     the in-service ceiling to drive int_out.
//   - Runs the two-pulse INTA handshake. Pulse 1 commits the winner to ISR.
//     Pulse 2 drives the vector {VECTOR_BASE, idx} onto the bus.
//   Optional feature macro: PIC_AEOI_EN. When it is defined, the ISR bit is
//   cleared automatically as the second INTA pulse ends.
//
// Ports
//   clk          system clock; all state changes on the rising edge
//   reset_n      asynchronous active-low reset
//   ir_in[7:0]   raw interrupt request lines (async, active high)
//   inta_n       CPU interrupt acknowledge (async, active low)
//   eoi_wr       1-cycle strobe: non-specific end-of-interrupt
//   imr_wr       1-cycle strobe: load the mask from imr_data
//   imr_data     new mask value (1 = masked)
//   int_out      interrupt request to the CPU
//   vector_out   vector byte; valid while vector_oe = 1
//   vector_oe    data-bus drive enable for vector_out
//   irr_out      interrupt request register
//   isr_out      in-service register
//   imr_out      interrupt mask register
//   busy         1 whenever the acknowledge FSM is not IDLE
// -----------------------------------------------------------------------------
module pic_ack_sequencer #(
  parameter logic [4:0] VECTOR_BASE = 5'h08,
  parameter int         SYNC_STAGES = 2      // legal 2..4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] ir_in,
  input  logic       inta_n,
  input  logic       eoi_wr,
  input  logic       imr_wr,
  input  logic [7:0] imr_data,
  output logic       int_out,
  output logic [7:0] vector_out,
  output logic       vector_oe,
  output logic [7:0] irr_out,
  output logic [7:0] isr_out,
  output logic [7:0] imr_out,
  output logic       busy
);

`ifdef PIC_AEOI_EN
  localparam bit AEOI_EN = 1'b1;
`else
  localparam bit AEOI_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ACK1, WAIT2, ACK2} state_t;

  state_t                      state;
  logic [SYNC_STAGES-1:0]      inta_sync;
  logic [SYNC_STAGES-1:0][7:0] ir_sync;
  logic                        inta_d;
  logic [7:0]                  ir_d;
  logic [7:0]                  irr, isr, imr;
  logic [2:0]                  sel_idx;
  logic                        sel_valid;

  logic       inta_fall, inta_rise;
  logic [7:0] ir_rise;
  logic [7:0] eligible;
  logic [3:0] win_idx, ceil_idx;
  logic       win_ok;
  logic       commit_valid, aeoi_clr;
  logic [7:0] irr_next, isr_next;

  // Synchroniser chains followed by one edge-detect flop. They reset to the
  // inactive level so that leaving reset never produces a false edge.
  // NOTE: every clocked register uses non-blocking assignments. The pipeline
  // stages then all sample their pre-edge values, whatever the statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inta_sync <= '1;
      inta_d    <= 1'b1;
      ir_sync   <= '0;
      ir_d      <= '0;
    end else begin
      inta_sync <= {inta_sync[SYNC_STAGES-2:0], inta_n};
      inta_d    <= inta_sync[SYNC_STAGES-1];
      ir_sync   <= {ir_sync[SYNC_STAGES-2:0], ir_in};
      ir_d      <= ir_sync[SYNC_STAGES-1];
    end
  end

  assign inta_fall = inta_d & ~inta_sync[SYNC_STAGES-1];
  assign inta_rise = ~inta_d & inta_sync[SYNC_STAGES-1];
  assign ir_rise   = ir_sync[SYNC_STAGES-1] & ~ir_d;

  // Priority resolution. Index 8 means "none" and loses against any real index.
  always_comb begin
    eligible = irr & ~imr;
    win_idx  = 4'd8;
    ceil_idx = 4'd8;
    for (int i = 7; i >= 0; i--) begin
      if (eligible[i]) win_idx  = 4'(i);
      if (isr[i])      ceil_idx = 4'(i);
    end
    win_ok = (win_idx < ceil_idx);
  end

  // Next IRR/ISR values. The order of the statements gives the precedence:
  // an EOI acts on the prior ISR before a same-cycle commit sets a new bit,
  // and a new request edge wins over the commit clearing its IRR bit.
  // NOTE: this block assigns a default to every output first, so no latch is
  // inferred on any path.
  always_comb begin
    commit_valid = (state == IDLE) && inta_fall && win_ok;
    aeoi_clr     = AEOI_EN && (state == ACK2) && inta_rise && sel_valid;

    irr_next = irr;
    if (commit_valid) irr_next[win_idx[2:0]] = 1'b0;
    irr_next = irr_next | ir_rise;

    // isr & (isr - 1) clears the lowest set bit. It leaves 0 unchanged.
    isr_next = eoi_wr ? (isr & (isr - 8'd1)) : isr;
    if (aeoi_clr)     isr_next[sel_idx]      = 1'b0;
    if (commit_valid) isr_next[win_idx[2:0]] = 1'b1;
  end

  // Acknowledge FSM, register file and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      irr        <= '0;
      isr        <= '0;
      imr        <= '0;
      sel_idx    <= '0;
      sel_valid  <= 1'b0;
      int_out    <= 1'b0;
      vector_out <= '0;
      vector_oe  <= 1'b0;
    end else begin
      irr <= irr_next;
      isr <= isr_next;
      if (imr_wr) imr <= imr_data;

      // The request drops in the same cycle the FSM leaves IDLE.
      int_out <= (state == IDLE) && !inta_fall && win_ok;

      unique case (state)
        IDLE: if (inta_fall) begin
          state     <= ACK1;
          sel_valid <= win_ok;
          sel_idx   <= win_ok ? win_idx[2:0] : 3'd7;  // spurious -> IR7 vector
        end
        ACK1: if (inta_rise) state <= WAIT2;
        WAIT2: if (inta_fall) begin
          state      <= ACK2;
          vector_out <= {VECTOR_BASE, sel_idx};
          vector_oe  <= 1'b1;
        end
        ACK2: if (inta_rise) begin
          state     <= IDLE;
          vector_oe <= 1'b0;   // vector_out keeps its last value
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy    = (state != IDLE);
  assign irr_out = irr;
  assign isr_out = isr;
  assign imr_out = imr;

endmodule

// File: tb/tb_pic_ack_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pic_ack_sequencer
//   Directed bench for pic_ack_sequencer (VECTOR_BASE = 5'h08, SYNC_STAGES = 2).
//   Expected vectors are queued when an acknowledge cycle starts. They are
//   popped and compared when vector_oe rises.
// -----------------------------------------------------------------------------
module tb_pic_ack_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] ir_in;
  logic       inta_n;
  logic       eoi_wr;
  logic       imr_wr;
  logic [7:0] imr_data;
  logic       int_out;
  logic [7:0] vector_out;
  logic       vector_oe;
  logic [7:0] irr_out, isr_out, imr_out;
  logic       busy;

`ifdef PIC_AEOI_EN
  localparam bit AEOI = 1'b1;
`else
  localparam bit AEOI = 1'b0;
`endif

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] sb_q[$];
  logic       prev_oe  = 1'b0;

  pic_ack_sequencer #(.VECTOR_BASE(5'h08), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ir_in      (ir_in),
    .inta_n     (inta_n),
    .eoi_wr     (eoi_wr),
    .imr_wr     (imr_wr),
    .imr_data   (imr_data),
    .int_out    (int_out),
    .vector_out (vector_out),
    .vector_oe  (vector_oe),
    .irr_out    (irr_out),
    .isr_out    (isr_out),
    .imr_out    (imr_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: on each rising vector_oe, pop the expected vector and compare.
  always @(negedge clk) begin
    if (reset_n && vector_oe && !prev_oe) begin
      if (sb_q.size() == 0) begin
        checks++;
        assert (1'b0) else begin
          failures++;
          $error("FAIL sb_unexpected: observed=%h expected=none", vector_out);
        end
      end else begin
        check("sb_vector", vector_out, sb_q.pop_front());
      end
    end
    prev_oe <= vector_oe;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_eoi();
    eoi_wr = 1'b1;
    wait_cycles(1);
    eoi_wr = 1'b0;
  endtask

  task automatic write_imr(input logic [7:0] v);
    imr_data = v;
    imr_wr   = 1'b1;
    wait_cycles(1);
    imr_wr   = 1'b0;
  endtask

  task automatic raise_ir(input logic [7:0] pins);
    ir_in = pins;
    wait_cycles(4);
    ir_in = 8'h00;
    wait_cycles(2);
  endtask

  // Full two-pulse acknowledge. isr1/irr1 are the register values expected
  // after the first pulse has been committed.
  task automatic ack_cycle(input string tag, input logic [7:0] vec,
                           input logic [7:0] isr1, input logic [7:0] irr1);
    sb_q.push_back(vec);
    inta_n = 1'b0;
    wait_cycles(6);
    check({tag, "_isr_p1"}, isr_out, isr1);
    check({tag, "_irr_p1"}, irr_out, irr1);
    check({tag, "_int_p1"}, int_out, 8'h0);
    check({tag, "_oe_p1"},  vector_oe, 8'h0);
    check({tag, "_busy_p1"}, busy, 8'h1);
    inta_n = 1'b1;
    wait_cycles(6);
    check({tag, "_oe_gap"}, vector_oe, 8'h0);
    inta_n = 1'b0;
    wait_cycles(6);
    check({tag, "_oe_p2"}, vector_oe, 8'h1);
    check({tag, "_isr_p2"}, isr_out, isr1);
    inta_n = 1'b1;
    wait_cycles(6);
    check({tag, "_oe_end"}, vector_oe, 8'h0);
    check({tag, "_busy_end"}, busy, 8'h0);
    check({tag, "_vec_held"}, vector_out, vec);
  endtask

  initial begin
    reset_n  = 1'b0;
    ir_in    = 8'h00;
    inta_n   = 1'b1;
    eoi_wr   = 1'b0;
    imr_wr   = 1'b0;
    imr_data = 8'h00;
    #1;
    check("rst_int", int_out, 8'h0);
    check("rst_oe", vector_oe, 8'h0);
    check("rst_vec", vector_out, 8'h00);
    check("rst_busy", busy, 8'h0);
    check("rst_irr", irr_out, 8'h00);
    check("rst_isr", isr_out, 8'h00);
    check("rst_imr", imr_out, 8'h00);
    wait_cycles(3);
    reset_n = 1'b1;
    wait_cycles(2);

    // IR3: edge latency, int_out, full acknowledge.
    ir_in = 8'h08;
    wait_cycles(2);
    check("ir3_lat2", irr_out, 8'h00);
    wait_cycles(1);
    check("ir3_lat3", irr_out, 8'h08);
    wait_cycles(2);
    check("ir3_int", int_out, 8'h1);
    ir_in = 8'h00;
    wait_cycles(2);
    ack_cycle("ir3", 8'h43, 8'h08, 8'h00);
    check("ir3_isr_after", isr_out, AEOI ? 8'h00 : 8'h08);
    pulse_eoi();
    wait_cycles(1);
    check("ir3_eoi", isr_out, 8'h00);

    // IR5 and IR2 together with IR2 masked: IR5 wins.
    write_imr(8'h04);
    check("imr_load", imr_out, 8'h04);
    raise_ir(8'h24);
    check("ir52_irr", irr_out, 8'h24);
    check("ir52_int", int_out, 8'h1);
    ack_cycle("ir5", 8'h45, 8'h20, 8'h04);
    pulse_eoi();
    wait_cycles(2);
    check("ir5_eoi", isr_out, 8'h00);
    check("ir2_masked_int", int_out, 8'h0);

    // Unmask IR2 and acknowledge it, then set up isr = 8'h02 through IR1.
    write_imr(8'h00);
    wait_cycles(2);
    check("ir2_unmasked_int", int_out, 8'h1);
    ack_cycle("ir2", 8'h42, 8'h04, 8'h00);
    pulse_eoi();
    raise_ir(8'h02);
    ack_cycle("ir1", 8'h41, 8'h02, 8'h00);
    if (AEOI) begin
      check("ir1_aeoi_isr", isr_out, 8'h00);
    end else begin
      // IR4 is below the in-service ceiling, so it must wait for the EOI.
      check("ir1_isr_held", isr_out, 8'h02);
      raise_ir(8'h10);
      check("ir4_blocked_irr", irr_out, 8'h10);
      check("ir4_blocked_int", int_out, 8'h0);
      pulse_eoi();
      wait_cycles(2);
      check("ir4_eoi_isr", isr_out, 8'h00);
      check("ir4_after_eoi_int", int_out, 8'h1);
      ack_cycle("ir4", 8'h44, 8'h10, 8'h00);
      pulse_eoi();
    end
    wait_cycles(2);
    check("idle_isr", isr_out, 8'h00);

    // Spurious acknowledge with nothing pending.
    ack_cycle("spur", 8'h47, 8'h00, 8'h00);
    check("spur_isr", isr_out, 8'h00);

    // IR6: ISR is cleared after ACK2 only in the auto-EOI build.
    raise_ir(8'h40);
    ack_cycle("ir6", 8'h46, 8'h40, 8'h00);
    check("ir6_isr_after", isr_out, AEOI ? 8'h00 : 8'h40);
    pulse_eoi();
    wait_cycles(1);
    check("ir6_eoi", isr_out, 8'h00);

    // Asynchronous reset in the middle of ACK2.
    raise_ir(8'h01);
    sb_q.push_back(8'h40);
    inta_n = 1'b0;
    wait_cycles(6);
    inta_n = 1'b1;
    wait_cycles(6);
    inta_n = 1'b0;
    wait_cycles(6);
    check("mid_oe_before", vector_oe, 8'h1);
    check("mid_isr_before", isr_out, 8'h01);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_oe", vector_oe, 8'h0);
    check("mid_rst_busy", busy, 8'h0);
    check("mid_rst_isr", isr_out, 8'h00);
    check("mid_rst_vec", vector_out, 8'h00);
    inta_n = 1'b1;
    wait_cycles(2);
    reset_n = 1'b1;
    wait_cycles(4);
    check("post_rst_busy", busy, 8'h0);
    check("post_rst_int", int_out, 8'h0);

    check("sb_empty", 8'(sb_q.size()), 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
